// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample sequencer slice.
package fir_pkg;

    localparam int FIR_CLK_DIV = 2272;
    localparam int FIR_TAPS    = 32;
    localparam int FIR_AW      = 5;
    localparam int FIR_MAC_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fir_state_t;

    typedef enum logic [1:0] {
        PARAMS_OK        = 2'd0,
        PARAMS_BAD_TAPS  = 2'd1,
        PARAMS_SHORT_DIV = 2'd2
    } fir_param_status_t;

    // Evaluated at elaboration: TAPS must fit the address space and the
    // sample period must leave room for a full MAC pass plus drain.
    function automatic fir_param_status_t fir_check_params(int clk_div, int taps,
                                                           int aw, int mac_lat);
        if (taps < 1 || taps > (1 << aw)) begin
            return PARAMS_BAD_TAPS;
        end
        if (clk_div < taps + mac_lat + 2) begin
            return PARAMS_SHORT_DIV;
        end
        return PARAMS_OK;
    endfunction

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Control/address bundle between the sequencer and the FIR datapath.
interface fir_sample_sequencer_if
    import fir_pkg::*;
#(
    parameter int AW = FIR_AW
);
    logic          run;
    logic          sample_en;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] coef_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    modport master (
        input  run,
        output sample_en, wr_ptr, rd_addr, coef_addr,
        output mac_clr, mac_en, out_valid, busy, overrun
    );

    modport slave (
        output run,
        input  sample_en, wr_ptr, rd_addr, coef_addr,
        input  mac_clr, mac_en, out_valid, busy, overrun
    );
endinterface

// File: rtl/fir_sample_sequencer_rate_divider.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while run is high, held at 0
// otherwise, with a combinational strobe on the terminal count.
module rate_divider
    import fir_pkg::*;
#(
    parameter int CLK_DIV = FIR_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic wrap
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign wrap = run && (count == LAST);

    // Free-running period counter, parked at zero whenever run is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/fir_sample_sequencer.sv
// Sequences one shared MAC across all FIR taps once per audio sample.
module fir_sample_sequencer
    import fir_pkg::*;
#(
    parameter int CLK_DIV = FIR_CLK_DIV,
    parameter int TAPS    = FIR_TAPS,
    parameter int AW      = FIR_AW,
    parameter int MAC_LAT = FIR_MAC_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fir_sample_sequencer_if.master  bus
);
    localparam fir_param_status_t PARAM_STATUS = fir_check_params(CLK_DIV, TAPS, AW, MAC_LAT);
    localparam logic [AW-1:0] LAST_TAP   = AW'(TAPS - 1);
    localparam logic [7:0]    LAST_DRAIN = 8'(MAC_LAT - 1);

    // A short sample period still elaborates; overrun reports the dropped
    // samples at runtime. A tap count outside the address space cannot work.
    if (PARAM_STATUS == PARAMS_BAD_TAPS) begin : g_bad_taps
        $error("fir_sample_sequencer: TAPS must be in 1..2**AW");
    end

    logic wrap;

    rate_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (bus.run),
        .wrap (wrap)
    );

    fir_state_t    state, state_nx;
    logic [AW-1:0] tap, tap_nx;
    logic [7:0]    drain, drain_nx;
    logic          sample_en, sample_en_nx;
    logic [AW-1:0] wr_ptr, wr_ptr_nx;
    logic [AW-1:0] rd_addr, rd_addr_nx;
    logic [AW-1:0] coef_addr, coef_addr_nx;
    logic          mac_clr, mac_clr_nx;
    logic          mac_en, mac_en_nx;
    logic          out_valid, out_valid_nx;
    logic          busy, busy_nx;
    logic          overrun, overrun_nx;

    // Next state and next registered outputs; a wrap is only accepted in a
    // truly idle cycle, otherwise the sample is dropped and flagged.
    always_comb begin
        state_nx     = state;
        tap_nx       = tap;
        drain_nx     = drain;
        sample_en_nx = 1'b0;
        wr_ptr_nx    = wr_ptr;
        rd_addr_nx   = rd_addr;
        coef_addr_nx = coef_addr;
        mac_clr_nx   = 1'b0;
        mac_en_nx    = 1'b0;
        out_valid_nx = 1'b0;
        busy_nx      = busy;
        overrun_nx   = overrun;

        case (state)
            IDLE: begin
                if (sample_en) begin
                    state_nx     = MAC;
                    tap_nx       = '0;
                    rd_addr_nx   = wr_ptr - 1'b1;
                    coef_addr_nx = '0;
                    mac_en_nx    = 1'b1;
                    mac_clr_nx   = 1'b1;
                    busy_nx      = 1'b1;
                end else if (wrap) begin
                    sample_en_nx = 1'b1;
                    wr_ptr_nx    = wr_ptr + 1'b1;
                end
            end
            MAC: begin
                if (tap == LAST_TAP) begin
                    if (MAC_LAT > 0) begin
                        state_nx = DRAIN;
                        drain_nx = '0;
                    end else begin
                        state_nx     = DONE;
                        out_valid_nx = 1'b1;
                    end
                end else begin
                    tap_nx       = tap + 1'b1;
                    rd_addr_nx   = rd_addr - 1'b1;
                    coef_addr_nx = tap + 1'b1;
                    mac_en_nx    = 1'b1;
                end
            end
            DRAIN: begin
                if (drain == LAST_DRAIN) begin
                    state_nx     = DONE;
                    out_valid_nx = 1'b1;
                end else begin
                    drain_nx = drain + 8'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase

        if (!bus.run) begin
            overrun_nx = 1'b0;
        end else if (wrap && (state != IDLE || sample_en)) begin
            overrun_nx = 1'b1;
        end
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap       <= '0;
            drain     <= '0;
            sample_en <= 1'b0;
            wr_ptr    <= '0;
            rd_addr   <= '0;
            coef_addr <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            tap       <= tap_nx;
            drain     <= drain_nx;
            sample_en <= sample_en_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_addr   <= rd_addr_nx;
            coef_addr <= coef_addr_nx;
            mac_clr   <= mac_clr_nx;
            mac_en    <= mac_en_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
            overrun   <= overrun_nx;
        end
    end

    assign bus.sample_en = sample_en;
    assign bus.wr_ptr    = wr_ptr;
    assign bus.rd_addr   = rd_addr;
    assign bus.coef_addr = coef_addr;
    assign bus.mac_clr   = mac_clr;
    assign bus.mac_en    = mac_en;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun;
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: a normal-period instance (CLK_DIV=20) and a
// deliberately short-period instance (CLK_DIV=10) share clock, reset and run,
// and are compared every cycle against a timeline model of strobe times.
module tb_fir_sample_sequencer;
    import fir_pkg::*;

    localparam int TAPS      = 8;
    localparam int AW        = 3;
    localparam int MAC_LAT   = 2;
    localparam int LAST_BUSY = TAPS + MAC_LAT + 1;
    localparam int NONE      = -100000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fir_sample_sequencer_if #(.AW(AW)) bus0 ();
    fir_sample_sequencer_if #(.AW(AW)) bus1 ();

    fir_sample_sequencer #(.CLK_DIV(20), .TAPS(TAPS), .AW(AW), .MAC_LAT(MAC_LAT)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    fir_sample_sequencer #(.CLK_DIV(10), .TAPS(TAPS), .AW(AW), .MAC_LAT(MAC_LAT)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    int passCount  = 0;
    int totalCount = 0;

    // Timeline model: cycles run since run last rose, time of the last
    // accepted strobe, expected write pointer and sticky overrun.
    int cyc = 0;
    int runCnt[2];
    int lastT[2];
    int wrM[2];
    bit ovM[2];
    bit runNow;

    function automatic int clkDiv(int i);
        return (i == 0) ? 20 : 10;
    endfunction

    task automatic checkOne(string tag, int i, logic [31:0] got, logic [31:0] want);
        totalCount++;
        assert (got === want) passCount++;
        else $error("[TB] FAIL %s dut%0d cycle %0d: observed %0h expected %0h",
                    tag, i, cyc, got, want);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            runCnt[i] = 0;
            lastT[i]  = NONE;
            wrM[i]    = 0;
            ovM[i]    = 1'b0;
        end
    endtask

    // Advance the model by one rising edge; a divider wrap is decided by the
    // cycle before the edge, which drops it if a computation is in progress.
    task automatic modelEdge();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!runNow) begin
                runCnt[i] = 0;
                ovM[i]    = 1'b0;
            end else begin
                runCnt[i]++;
                if (runCnt[i] % clkDiv(i) == 0) begin
                    if (cyc - 1 >= lastT[i] && cyc - 1 <= lastT[i] + LAST_BUSY) begin
                        ovM[i] = 1'b1;
                    end else begin
                        lastT[i] = cyc;
                        wrM[i]   = (wrM[i] + 1) % (1 << AW);
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(int i);
        int d;
        logic se, mc, me, ov, bz, orn;
        logic [AW-1:0] wp, ra, ca;
        d = cyc - lastT[i];
        if (i == 0) begin
            se = bus0.sample_en; mc = bus0.mac_clr; me = bus0.mac_en; ov = bus0.out_valid;
            bz = bus0.busy; orn = bus0.overrun; wp = bus0.wr_ptr; ra = bus0.rd_addr; ca = bus0.coef_addr;
        end else begin
            se = bus1.sample_en; mc = bus1.mac_clr; me = bus1.mac_en; ov = bus1.out_valid;
            bz = bus1.busy; orn = bus1.overrun; wp = bus1.wr_ptr; ra = bus1.rd_addr; ca = bus1.coef_addr;
        end
        checkOne("sample_en", i, 32'(se), 32'(d == 0));
        checkOne("mac_en",    i, 32'(me), 32'(d >= 1 && d <= TAPS));
        checkOne("mac_clr",   i, 32'(mc), 32'(d == 1));
        checkOne("busy",      i, 32'(bz), 32'(d >= 1 && d <= LAST_BUSY));
        checkOne("out_valid", i, 32'(ov), 32'(d == LAST_BUSY));
        checkOne("overrun",   i, 32'(orn), 32'(ovM[i]));
        checkOne("wr_ptr",    i, 32'(wp), 32'(wrM[i]));
        if (d >= 1 && d <= TAPS) begin
            checkOne("rd_addr",   i, 32'(ra), 32'((((wrM[i] - d) % 8) + 8) % 8));
            checkOne("coef_addr", i, 32'(ca), 32'(d - 1));
        end
    endtask

    task automatic checkZero(int i);
        logic [9:0] all;
        if (i == 0) begin
            all = {bus0.sample_en, bus0.mac_clr, bus0.mac_en, bus0.out_valid, bus0.busy,
                   bus0.overrun, (|bus0.wr_ptr), (|bus0.rd_addr), (|bus0.coef_addr), 1'b0};
        end else begin
            all = {bus1.sample_en, bus1.mac_clr, bus1.mac_en, bus1.out_valid, bus1.busy,
                   bus1.overrun, (|bus1.wr_ptr), (|bus1.rd_addr), (|bus1.coef_addr), 1'b0};
        end
        checkOne("reset_outputs", i, 32'(all), 32'd0);
    endtask

    // Hold run at r for n cycles, checking both instances after every edge.
    task automatic applyStimulus(bit r, int n);
        for (int c = 0; c < n; c++) begin
            runNow   = r;
            bus0.run = r;
            bus1.run = r;
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkOutput(0);
            checkOutput(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        rst_n    = 1'b0;
        runNow   = 1'b0;
        bus0.run = 1'b0;
        bus1.run = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkZero(0);
        checkZero(1);
        rst_n = 1'b1;

        $display("[TB] run from reset: first strobe, tap sequence, pointer wrap");
        applyStimulus(1'b1, 230);

        $display("[TB] drop run during MAC");
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            applyStimulus(1'b1, 1);
            if (cyc - lastT[0] == 3) found = 1'b1;
        end
        checkOne("wait_mac_run_drop", 0, 32'(found), 32'd1);
        applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 45);

        $display("[TB] randomized run pattern");
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 60));
        end

        $display("[TB] reset at MAC k=4");
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            applyStimulus(1'b1, 1);
            if (cyc - lastT[0] == 5) found = 1'b1;
        end
        checkOne("wait_mac_k4", 0, 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        checkZero(0);
        checkZero(1);
        modelReset();
        runNow   = 1'b0;
        bus0.run = 1'b0;
        bus1.run = 1'b0;
        @(negedge clk);
        checkZero(0);
        checkZero(1);
        rst_n = 1'b1;
        applyStimulus(1'b1, 60);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Controller for the simulation FIR chain. It divides the system clock down to the 44 kHz audio sample rate and issues the one-cycle `sample_en` strobe that advances the tone generator and writes its output into the circular sample buffer. It then sequences a single shared multiply-accumulate unit across all filter taps by driving sample-buffer and coefficient-ROM addresses plus the MAC control lines. It flags each completed output sample.

## Interface
- `CLK_DIV`, 2272: system clocks per audio sample (100 MHz / 44 kHz); legal range ≥ `TAPS+MAC_LAT+2`.
- `TAPS`, 32: number of filter taps; 1 ≤ `TAPS` ≤ 2**`AW`.
- `AW`, 5: sample-buffer and coefficient address width.
- `MAC_LAT`, 2: pipeline latency of the external MAC, from the `mac_en` cycle to the updated accumulator.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  enables the sample-rate divider.
- `sample_en`  out  1  one-cycle strobe to tone generator `en` and to the sample-buffer write enable.
- `wr_ptr`  out  AW  sample-buffer write address.
- `rd_addr`  out  AW  sample-buffer read address.
- `coef_addr`  out  AW  coefficient ROM address.
- `mac_clr`  out  1  load the product instead of accumulating it (first tap).
- `mac_en`  out  1  MAC operand valid.
- `out_valid`  out  1  one-cycle strobe; accumulator holds the finished output.
- `busy`  out  1  high from the first MAC cycle through the `out_valid` cycle.
- `overrun`  out  1  sticky; a sample strobe arrived while `busy` was high.

## Operation
- All outputs are registered. On reset every output is 0 and the state is IDLE; reset takes effect immediately, including mid-computation.
- Divider counts 0..`CLK_DIV-1` while `run`=1 and wraps at the top. When `run`=0 the divider is held at 0 and no strobes are produced. An in-flight computation always completes.
- A divider wrap in IDLE produces `sample_en`=1 for that cycle. The buffer writes at the current `wr_ptr`, and `wr_ptr` increments modulo 2**`AW` on the same edge.
- State machine: IDLE → MAC (`TAPS` cycles) → DRAIN (`MAC_LAT` cycles) → DONE (1 cycle) → IDLE.
- MAC cycle k (k = 0..`TAPS-1`):
  - `rd_addr` = `wr_ptr` − 1 − k mod 2**`AW`, so k=0 reads the newest sample.
  - `coef_addr` = k.
  - `mac_en`=1 throughout; `mac_clr`=1 only when k=0.
- Address arithmetic is unsigned `AW`-bit and wraps silently through 0.
- DONE: `out_valid`=1 for that cycle.
- A divider wrap while the state is not IDLE:
  - `sample_en` is suppressed and the sample is dropped.
  - `overrun` is set.
  - The divider keeps free-running.
- `overrun` clears only on reset or when `run`=0.

## Timing
- Cycle T is the `sample_en` cycle.
- MAC k=0..`TAPS-1` occupies cycles T+1..T+`TAPS`.
- DRAIN occupies cycles T+`TAPS`+1..T+`TAPS`+`MAC_LAT`.
- `out_valid` is high at cycle T+`TAPS`+`MAC_LAT`+1.
- `busy` is high from T+1 through the `out_valid` cycle inclusive.
- Consecutive `sample_en` strobes are exactly `CLK_DIV` cycles apart while `run`=1 and no overrun occurs.
- First strobe after `run` rises: `CLK_DIV` cycles later.

## Structure
- Shared package `fir_pkg` holds:
  - the state enum (IDLE, MAC, DRAIN, DONE);
  - default constants `FIR_CLK_DIV`, `FIR_TAPS`, `FIR_AW`, `FIR_MAC_LAT`;
  - an elaboration-time check function for the `CLK_DIV` and `TAPS` legality constraints.
- Sub-module `rate_divider`: counter with `run` hold and single-cycle wrap strobe. The FSM, tap counter and address generation stay in the top level.

## Test plan
Unless stated otherwise, benches use `CLK_DIV`=20, `TAPS`=8, `AW`=3, `MAC_LAT`=2.
- Reset, then `run`=1 → first `sample_en` at cycle 20; `mac_clr` at cycle 21; `mac_en` on cycles 21–28; `out_valid` at cycle 31. `busy` is high on cycles 21–31.
- After the first strobe (`wr_ptr` now 1) → `rd_addr` sequence 0,7,6,5,4,3,2,1 and `coef_addr` 0..7.
- Run 10 samples → `wr_ptr` wraps 7→0. Strobes are spaced exactly 20 cycles apart; `overrun` stays 0.
- With `CLK_DIV`=10 → the second wrap falls during DRAIN: no `sample_en`, `overrun`=1 and sticky. Dropping `run` to 0 clears it.
- Drop `run` during MAC → the computation completes with `out_valid`, then there are no further strobes and the divider reads 0.
- Assert `rst_n`=0 at MAC k=4 → all outputs are 0 in the same cycle. After release, IDLE and `wr_ptr`=0.
